// File: rtl/sprite_cmd_queue_if.sv
// sprite_cmd_queue_if: Avalon write port, VGA position and display-bus outputs of the sprite command queue.
// Define SPRITE_CMD_STATS_EN to add the drop_count/flush_count statistics signals.
interface sprite_cmd_queue_if;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata_in;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [31:0] writedata;
    logic        disp_select;
    logic        fifo_full;
    logic        overflow;
`ifdef SPRITE_CMD_STATS_EN
    logic [15:0] drop_count;
    logic [15:0] flush_count;
    modport master (
        output chipselect, write, writedata_in, hcount, vcount,
        input  writedata, disp_select, fifo_full, overflow, drop_count, flush_count
    );
    modport slave (
        input  chipselect, write, writedata_in, hcount, vcount,
        output writedata, disp_select, fifo_full, overflow, drop_count, flush_count
    );
`else
    modport master (
        output chipselect, write, writedata_in, hcount, vcount,
        input  writedata, disp_select, fifo_full, overflow
    );
    modport slave (
        input  chipselect, write, writedata_in, hcount, vcount,
        output writedata, disp_select, fifo_full, overflow
    );
`endif
endinterface

// File: rtl/sprite_cmd_queue.sv
// sprite_cmd_queue: buffers HPS sprite commands and replays them one per cycle, holding buffer-swap flushes until vblank.
// Define SPRITE_CMD_STATS_EN to add drop_count/flush_count outputs.
module sprite_cmd_queue #(
    parameter int         DEPTH   = 64,
    parameter int         AW      = 6,
    parameter logic [9:0] VACTIVE = 10'd480
) (
    input logic               clk,
    input logic               reset,
    sprite_cmd_queue_if.slave bus
);
    typedef enum logic {DRAIN, WAIT_VB} state_t;
    state_t      r_state, w_state_nx;
    logic [31:0] r_mem [DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic [31:0] r_writedata, w_head;
    logic        r_disp_select, r_overflow, r_frame_flushed;
    logic        w_full, w_empty, w_req, w_push, w_drop, w_pop, w_issue, w_frame_start;
    assign w_empty       = r_wr_ptr == r_rd_ptr;
    assign w_full        = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_req         = bus.chipselect && bus.write;
    assign w_push        = w_req && !w_full;
    assign w_drop        = w_req && w_full;
    assign w_head        = r_mem[r_rd_ptr[AW-1:0]];
    assign w_frame_start = bus.vcount == 10'd0 && bus.hcount == 10'd0;
    always_comb begin
        w_state_nx = r_state;
        w_pop      = 1'b0;
        w_issue    = 1'b0;
        if (r_state == DRAIN) begin
            if (!w_empty && w_head[20:17] == 4'b1111) w_state_nx = WAIT_VB;
            else w_pop = !w_empty;
        end else if (bus.vcount >= VACTIVE && !r_frame_flushed) begin
            w_pop      = 1'b1;
            w_issue    = 1'b1;
            w_state_nx = DRAIN;
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= bus.writedata_in;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= DRAIN;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_writedata     <= 32'h0;
            r_disp_select   <= 1'b0;
            r_overflow      <= 1'b0;
            r_frame_flushed <= 1'b0;
        end else begin
            r_state         <= w_state_nx;
            r_wr_ptr        <= r_wr_ptr + {{AW{1'b0}}, w_push};
            r_rd_ptr        <= r_rd_ptr + {{AW{1'b0}}, w_pop};
            r_writedata     <= w_pop ? w_head : 32'h0;
            r_overflow      <= r_overflow | w_drop;
            r_disp_select   <= w_issue ? w_head[13] : r_disp_select;
            r_frame_flushed <= w_issue | (r_frame_flushed & !w_frame_start);
        end
    end
    assign bus.writedata   = r_writedata;
    assign bus.disp_select = r_disp_select;
    assign bus.fifo_full   = w_full;
    assign bus.overflow    = r_overflow;
`ifdef SPRITE_CMD_STATS_EN
    logic [15:0] r_drop_count, r_flush_count;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_count  <= 16'h0;
            r_flush_count <= 16'h0;
        end else begin
            r_drop_count  <= (w_drop && r_drop_count != 16'hFFFF) ? r_drop_count + 16'd1 : r_drop_count;
            r_flush_count <= r_flush_count + {15'd0, w_issue};
        end
    end
    assign bus.drop_count  = r_drop_count;
    assign bus.flush_count = r_flush_count;
`endif
endmodule

// File: tb/tb_sprite_cmd_queue.sv
// tb_sprite_cmd_queue: vector table, directed flush/overflow/reset sequences and random traffic against a queue-based model.
module tb_sprite_cmd_queue;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sprite_cmd_queue_if bus();
    sprite_cmd_queue dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [31:0] mq[$];
    logic [31:0] seen[$];
    logic [31:0] pushed[$];
    logic m_held, m_ff, m_disp, m_ovf;
    logic [31:0] m_wd;
    int m_drops, m_flushes;

    typedef struct {
        logic        wr;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_held = 0; m_ff = 0; m_disp = 0; m_ovf = 0; m_wd = 0;
        m_drops = 0; m_flushes = 0;
    endtask

    function automatic bit is_flush(input logic [31:0] w);
        return w[20:17] == 4'hF;
    endfunction

    // One clock: drive inputs, advance the model, then compare just after the edge.
    task automatic step(input logic wr, input logic [31:0] d, input logic [9:0] vc, input logic [9:0] hc = 10'd5);
        bit full, issue;
        bus.chipselect = wr; bus.write = wr; bus.writedata_in = d;
        bus.vcount = vc; bus.hcount = hc;
        full = mq.size() == 64;
        issue = 0;
        m_wd = 32'h0;
        if (mq.size() > 0) begin
            if (!is_flush(mq[0])) m_wd = mq.pop_front();
            else if (!m_held) m_held = 1;
            else if (vc >= 10'd480 && !m_ff) begin
                m_disp = mq[0][13];
                m_wd = mq.pop_front();
                m_ff = 1; m_held = 0; issue = 1;
                m_flushes++;
            end
        end
        if (!issue && vc == 10'd0 && hc == 10'd0) m_ff = 0;
        if (wr) begin
            if (full) begin
                m_ovf = 1;
                if (m_drops < 65535) m_drops++;
            end else mq.push_back(d);
        end
        @(posedge clk);
        #1;
        chk("writedata", bus.writedata, m_wd);
        chk("status", {29'b0, bus.disp_select, bus.fifo_full, bus.overflow},
            {29'b0, m_disp, mq.size() == 64, m_ovf});
        if (bus.writedata != 32'h0) seen.push_back(bus.writedata);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ord[5];
        logic [31:0] d;
        logic [9:0] vc;
        int n;
        bus.chipselect = 0; bus.write = 0; bus.writedata_in = 0;
        bus.hcount = 0; bus.vcount = 0;
        model_reset();
        #12;
        chk("reset_writedata", bus.writedata, 32'h0);
        chk("reset_status", {29'b0, bus.disp_select, bus.fifo_full, bus.overflow}, 32'h0);
        #5 reset = 1'b0;

        vecs[0] = '{1'b1, 32'h24021005, 32'h0};
        vecs[1] = '{1'b0, 32'h0, 32'h24021005};
        vecs[2] = '{1'b0, 32'h0, 32'h0};
        vecs[3] = '{1'b1, 32'h00020A11, 32'h0};
        vecs[4] = '{1'b1, 32'h00020B22, 32'h00020A11};
        vecs[5] = '{1'b0, 32'h0, 32'h00020B22};
        vecs[6] = '{1'b0, 32'h0, 32'h0};
        foreach (vecs[i]) begin
            step(vecs[i].wr, vecs[i].d, 10'd100);
            chk("table", bus.writedata, vecs[i].exp);
        end

        ord = '{32'h00020A01, 32'h00020B02, 32'h00020C03, 32'h001E2F0F, 32'h00020D04};
        seen.delete();
        foreach (ord[i]) step(1'b1, ord[i], 10'd100);
        repeat (6) step(1'b0, 32'h0, 10'd100);
        chk("held_before_vb", 32'(seen.size()), 32'd3);
        repeat (4) step(1'b0, 32'h0, 10'd480);
        chk("order_len", 32'(seen.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk("order", (i < seen.size()) ? seen[i] : 32'hDEADDEAD, ord[i]);
        chk("disp_after_flush", {31'b0, bus.disp_select}, 32'd1);

        step(1'b0, 32'h0, 10'd0, 10'd0);
        seen.delete();
        step(1'b1, 32'h001E2001, 10'd490);
        step(1'b1, 32'h001E0002, 10'd490);
        repeat (6) step(1'b0, 32'h0, 10'd490);
        chk("one_flush_per_frame", 32'(seen.size()), 32'd1);
        repeat (3) step(1'b0, 32'h0, 10'd520);
        chk("disp_still_1", {31'b0, bus.disp_select}, 32'd1);
        step(1'b0, 32'h0, 10'd0, 10'd0);
        repeat (3) step(1'b0, 32'h0, 10'd480);
        chk("second_flush", (seen.size() > 1) ? seen[1] : 32'hDEADDEAD, 32'h001E0002);
        chk("disp_after_second", {31'b0, bus.disp_select}, 32'd0);

        step(1'b1, 32'h001E2F00, 10'd100);
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 32'h00020000 | 32'(i), 10'd100);
            if (i == 62) chk("full_at_64", {30'b0, bus.fifo_full, bus.overflow}, 32'b10);
        end
        chk("overflow_set", {30'b0, bus.fifo_full, bus.overflow}, 32'b11);
`ifdef SPRITE_CMD_STATS_EN
        chk("drop_count", {16'b0, bus.drop_count}, 32'd1);
`endif
        step(1'b0, 32'h0, 10'd100);
        chk("overflow_sticky", {31'b0, bus.overflow}, 32'd1);

        step(1'b0, 32'h0, 10'd0, 10'd0);
        repeat (54) step(1'b0, 32'h0, 10'd480);
        chk("queued_before_reset", 32'(mq.size()), 32'd10);
        #2 reset = 1'b1;
        #1;
        chk("async_reset", {bus.writedata[31:3], bus.writedata[2:0] | {bus.disp_select, bus.overflow, bus.fifo_full}}, 32'h0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        seen.delete();
        repeat (5) step(1'b0, 32'h0, 10'd480);
        chk("no_stale", 32'(seen.size()), 32'd0);

        seen.delete();
        pushed.delete();
        for (int k = 0; k < 200; k++) begin
            d = $urandom;
            d[20:17] = 4'($urandom_range(1, 14));
            if ($urandom_range(0, 9) < 7) begin
                pushed.push_back(d);
                step(1'b1, d, 10'($urandom_range(0, 524)), 10'($urandom_range(1, 799)));
            end else step(1'b0, 32'h0, 10'd100);
        end
        n = 0;
        while (mq.size() > 0 && n < 100) begin
            step(1'b0, 32'h0, 10'd100);
            n++;
        end
        step(1'b0, 32'h0, 10'd100);
        chk("wrap_count", 32'(seen.size()), 32'(pushed.size()));
        for (int i = 0; i < pushed.size(); i++)
            chk("wrap_order", (i < seen.size()) ? seen[i] : 32'hDEADDEAD, pushed[i]);

        for (int k = 0; k < 400; k++) begin
            d = $urandom;
            d[20:17] = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            vc = 10'((k * 10) % 530);
            step(1'($urandom_range(0, 1)), d, vc, 10'd0);
        end
`ifdef SPRITE_CMD_STATS_EN
        chk("flush_count", {16'b0, bus.flush_count}, 32'(m_flushes));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
